// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type, iteration count and operand helpers
// shared by the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Magnitude of a 32-bit operand; unsigned ops pass the value through.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on magnitudes.
//   multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier};
//             add operand when the multiplier LSB is set, then shift right.
//   divide:   {acc_hi, acc_lo} holds {partial remainder, remaining dividend};
//             shift left, subtract operand when it fits (restoring step).
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;

    // Select a shift-add or restore-subtract step by op class.
    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, operand};
        shifted = {acc_hi, acc_lo[31]};
        // When the subtract is taken the true difference is below operand,
        // so the low 32 bits are exact.
        diff    = shifted[31:0] - operand;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                next_hi = diff;
                next_lo = {acc_lo[30:0], 1'b1};
            end else begin
                next_hi = shifted[31:0];
                next_lo = {acc_lo[30:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            next_hi = sum[32:1];
            next_lo = {sum[0], acc_lo[31:1]};
        end else begin
            next_hi = {1'b0, acc_hi[31:1]};
            next_lo = {acc_hi[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit mult/multu/div/divu unit, IDLE -> CALC -> DONE.
// Build macro MULDIV_FAST_MULT_EN: mult/multu use a single-cycle combinational
// product and go IDLE -> DONE directly; div/divu unchanged.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        write_HI_LO,
    output logic [31:0] ALU_HI,
    output logic [31:0] ALU_LO,
    output logic        div_by_zero
);

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, mag_b;
    logic        is_div_r, neg_q, neg_r, dbz_r;
    logic [31:0] step_hi, step_lo;
    logic        in_signed, in_div, b_zero, accept, direct, last_iter;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_raw, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign b_zero    = (src_b == 32'd0);
    assign a_mag     = abs32(src_a, in_signed);
    assign b_mag     = abs32(src_b, in_signed);
    assign accept    = (state == S_IDLE) && start && !cancel;
    assign last_iter = (cnt == 5'(ITER - 1));

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_raw, fast_prod;
    assign direct    = in_div ? b_zero : 1'b1;
    assign fast_raw  = {32'd0, a_mag} * {32'd0, b_mag};
    assign fast_prod = (in_signed && (src_a[31] ^ src_b[31])) ? -fast_raw : fast_raw;
`else
    assign direct    = in_div && b_zero;
`endif

    // Final sign fix-up applied to the last iteration's magnitudes.
    assign prod_raw = {step_hi, step_lo};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;
    assign quo_fix  = neg_q ? -step_lo : step_lo;
    assign rem_fix  = neg_r ? -step_hi : step_hi;

    muldiv_step u_step (
        .is_div  (is_div_r),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (mag_b),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and write strobe; cancel beats completion and suppresses the pulse.
    always_comb begin
        next_state  = state;
        write_HI_LO = 1'b0;
        div_by_zero = 1'b0;
        case (state)
            S_IDLE: if (start && !cancel) next_state = direct ? S_DONE : S_CALC;
            S_CALC: begin
                if (cancel)         next_state = S_IDLE;
                else if (last_iter) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
                if (!cancel) begin
                    write_HI_LO = 1'b1;
                    div_by_zero = dbz_r;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath, result registers and registered busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            is_div_r <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_r    <= 1'b0;
            ALU_HI   <= '0;
            ALU_LO   <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= (next_state != S_IDLE);
            if (accept) begin
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                mag_b    <= b_mag;
                is_div_r <= in_div;
                neg_q    <= in_signed && (src_a[31] ^ src_b[31]);
                neg_r    <= in_signed && src_a[31];
                dbz_r    <= in_div && b_zero;
                if (in_div && b_zero) begin
                    ALU_HI <= src_a;
                    ALU_LO <= 32'hFFFF_FFFF;
                end
`ifdef MULDIV_FAST_MULT_EN
                else if (!in_div) begin
                    {ALU_HI, ALU_LO} <= fast_prod;
                end
`endif
            end else if (state == S_CALC && !cancel) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 5'd1;
                if (last_iter) begin
                    if (is_div_r) begin
                        ALU_HI <= rem_fix;
                        ALU_LO <= quo_fix;
                    end else begin
                        {ALU_HI, ALU_LO} <= prod_fix;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq; directed spec vectors plus
// random operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        busy, write_HI_LO, div_by_zero;
    logic [31:0] ALU_HI, ALU_LO;

    int tests = 0;
    int fails = 0;

    localparam int WIN = 45;

    muldiv_seq dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .busy        (busy),
        .write_HI_LO (write_HI_LO),
        .ALU_HI      (ALU_HI),
        .ALU_LO      (ALU_LO),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Cycles from the accepting edge to the write pulse (cycle 1 = first cycle after it).
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    // Reference model from the arithmetic definition using 64-bit math.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        sa  = $signed({{32{a[31]}}, a});
        sb  = $signed({{32{b[31]}}, b});
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (o)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one operation and watch a bounded window. Inputs are scrambled after
    // the accepting edge; optional cancel / repeated start at a given cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input int restart_at,
                         output int first, output int npulse,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dbz, output logic busy_chk);
        first = 0; npulse = 0; hi = '0; lo = '0; dbz = 1'b0; busy_chk = 1'b0;
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clock);
            start  = (k == restart_at);
            cancel = (k == cancel_at);
            op     = 2'($urandom_range(3));
            src_a  = $urandom;
            src_b  = $urandom;
            #1;
            if (k == cancel_at + 1) busy_chk = busy;
            if (write_HI_LO) begin
                npulse++;
                if (first == 0) begin
                    first = k; hi = ALU_HI; lo = ALU_LO; dbz = div_by_zero;
                end
            end
        end
        start = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (busy !== 1'b0 || write_HI_LO !== 1'b0 || div_by_zero !== 1'b0 ||
            ALU_HI !== 32'd0 || ALU_LO !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b wr=%b dbz=%b hi=%h lo=%h, required all zero",
                     busy, write_HI_LO, div_by_zero, ALU_HI, ALU_LO);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        int first, npulse;
        logic [31:0] hi, lo;
        logic dbz, bc;
        v[0] = '{2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        v[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[3] = '{2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
        v[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        v[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        v[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        v[7] = '{2'b10, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].a, v[i].b, -5, -5, first, npulse, hi, lo, dbz, bc);
            tests++;
            if (first !== exp_lat(v[i].op, v[i].b) || npulse !== 1 || hi !== v[i].hi ||
                lo !== v[i].lo || dbz !== v[i].dbz) begin
                fails++;
                $display("FAIL directed[%0d]: got lat=%0d n=%0d hi=%h lo=%h dbz=%b, required lat=%0d n=1 hi=%h lo=%h dbz=%b",
                         i, first, npulse, hi, lo, dbz, exp_lat(v[i].op, v[i].b), v[i].hi, v[i].lo, v[i].dbz);
            end
        end
    endtask

    task automatic test_random();
        int first, npulse;
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic dbz, edbz, bc;
        logic [1:0] o;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(3));
            a = $urandom;
            b = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(3) == 0) b = b & 32'h0000_00FF;
            model(o, a, b, ehi, elo, edbz);
            issue(o, a, b, -5, -5, first, npulse, hi, lo, dbz, bc);
            tests++;
            if (first !== exp_lat(o, b) || npulse !== 1 || hi !== ehi || lo !== elo || dbz !== edbz) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d n=%0d hi=%h lo=%h dbz=%b, required lat=%0d n=1 hi=%h lo=%h dbz=%b",
                         i, o, a, b, first, npulse, hi, lo, dbz, exp_lat(o, b), ehi, elo, edbz);
            end
        end
    endtask

    task automatic test_cancel();
        int first, npulse;
        logic [31:0] hi, lo, ehi, elo;
        logic dbz, edbz, bc;
        // Cancel in cycle 10 of CALC.
        issue(2'b10, 32'd1000, 32'd7, 10, -5, first, npulse, hi, lo, dbz, bc);
        tests++;
        if (npulse !== 0 || bc !== 1'b0) begin
            fails++;
            $display("FAIL cancel_calc: pulses=%0d busy_next=%b, required 0 and 0", npulse, bc);
        end
        // Cancel during the DONE cycle of an iterative divide.
        issue(2'b11, 32'd99, 32'd4, 33, -5, first, npulse, hi, lo, dbz, bc);
        tests++;
        if (npulse !== 0 || bc !== 1'b0) begin
            fails++;
            $display("FAIL cancel_done: pulses=%0d busy_next=%b, required 0 and 0", npulse, bc);
        end
        // A new operation after cancel runs normally.
        model(2'b00, 32'hFFFF_FF00, 32'd12345, ehi, elo, edbz);
        issue(2'b00, 32'hFFFF_FF00, 32'd12345, -5, -5, first, npulse, hi, lo, dbz, bc);
        tests++;
        if (first !== exp_lat(2'b00, 32'd12345) || npulse !== 1 || hi !== ehi || lo !== elo) begin
            fails++;
            $display("FAIL after_cancel: got lat=%0d n=%0d hi=%h lo=%h, required lat=%0d n=1 hi=%h lo=%h",
                     first, npulse, hi, lo, exp_lat(2'b00, 32'd12345), ehi, elo);
        end
    endtask

    task automatic test_start_while_busy();
        int first, npulse;
        logic [31:0] hi, lo, ehi, elo;
        logic dbz, edbz, bc;
        model(2'b10, 32'hFFFF_F000, 32'd37, ehi, elo, edbz);
        issue(2'b10, 32'hFFFF_F000, 32'd37, -5, 5, first, npulse, hi, lo, dbz, bc);
        tests++;
        if (first !== 33 || npulse !== 1 || hi !== ehi || lo !== elo) begin
            fails++;
            $display("FAIL start_while_busy: got lat=%0d n=%0d hi=%h lo=%h, required lat=33 n=1 hi=%h lo=%h",
                     first, npulse, hi, lo, ehi, elo);
        end
    endtask

    task automatic test_start_cancel_idle();
        int npulse = 0;
        logic bsy;
        @(negedge clock);
        start = 1'b1; cancel = 1'b1; op = 2'b11; src_a = 32'd5; src_b = 32'd0;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        #1 bsy = busy;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            #1 if (write_HI_LO) npulse++;
        end
        tests++;
        if (bsy !== 1'b0 || npulse !== 0) begin
            fails++;
            $display("FAIL start_and_cancel_idle: busy=%b pulses=%0d, required busy=0 pulses=0", bsy, npulse);
        end
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        int first, np;
        logic [31:0] hi, lo, ehi, elo;
        logic dbz, edbz, bc;
        @(negedge clock);
        start = 1'b1; op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h0000_0F0F;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || write_HI_LO !== 1'b0 || ALU_HI !== 32'd0 || ALU_LO !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_async: busy=%b wr=%b hi=%h lo=%h, required all zero",
                     busy, write_HI_LO, ALU_HI, ALU_LO);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            #1 if (write_HI_LO || busy) npulse++;
        end
        tests++;
        if (npulse !== 0) begin
            fails++;
            $display("FAIL reset_mid_release: active cycles=%0d, required 0", npulse);
        end
        model(2'b01, 32'hDEAD_BEEF, 32'h0001_0001, ehi, elo, edbz);
        issue(2'b01, 32'hDEAD_BEEF, 32'h0001_0001, -5, -5, first, np, hi, lo, dbz, bc);
        tests++;
        if (first !== exp_lat(2'b01, 32'h0001_0001) || np !== 1 || hi !== ehi || lo !== elo) begin
            fails++;
            $display("FAIL after_reset: got lat=%0d n=%0d hi=%h lo=%h, required lat=%0d n=1 hi=%h lo=%h",
                     first, np, hi, lo, exp_lat(2'b01, 32'h0001_0001), ehi, elo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_start_while_busy();
        test_start_cancel_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
